// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-stream UART bridge.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: input synchroniser, 8N1 deserialiser and a one-entry
// output register with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       uart_rx_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST  = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q;
    logic                      rx_s;
    rx_state_t                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      stop_hit;
    logic                      deliver;

    assign rx_s     = sync_q[1];
    assign stop_hit = (state_q == RX_STOP) && (cnt_q == '0);
    assign deliver  = stop_hit && rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make both stages sample pre-edge
        // values; blocking would collapse the chain into a single flop.
        if (!rstn_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
        end
    end

    // Receive FSM: find start edge, sample mid-bit, check the stop bit.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_q <= RX_START;
                        cnt_q   <= HALF;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q   <= RX_DATA;
                            cnt_q     <= FULL;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        cnt_q   <= FULL;
                        if (bit_idx_q == LAST) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // One-entry output register; a same-cycle handshake frees the slot.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else if (deliver && (!out_valid_o || out_ready_i)) begin
            out_valid_o <= 1'b1;
            out_data_o  <= shift_q;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Registered single-cycle error pulses.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_frame_err_o <= 1'b0;
            rx_overrun_o   <= 1'b0;
        end else begin
            rx_frame_err_o <= stop_hit && !rx_s;
            rx_overrun_o   <= deliver && out_valid_o && !out_ready_i;
        end
    end

endmodule

// File: rtl/uart_stream.sv
// Byte-stream to UART bridge: 8N1 transmitter on the in_* stream and a
// receiver feeding the out_* stream. TX and RX run independently.
module uart_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       uart_tx_o,
    input  logic       uart_rx_i,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;

    // Transmit FSM: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_o  <= 1'b1;
            in_ready_o <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        state_q    <= TX_START;
                        shift_q    <= in_data_i;
                        cnt_q      <= FULL;
                        uart_tx_o  <= 1'b0;
                        in_ready_o <= 1'b0;
                    end else begin
                        in_ready_o <= 1'b1;
                    end
                end
                TX_START: begin
                    if (cnt_q == '0) begin
                        state_q   <= TX_DATA;
                        uart_tx_o <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        cnt_q     <= FULL;
                        bit_idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= FULL;
                        if (bit_idx_q == LAST) begin
                            state_q   <= TX_STOP;
                            uart_tx_o <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            uart_tx_o <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt_q == '0) begin
                        state_q    <= TX_IDLE;
                        in_ready_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= TX_IDLE;
                    uart_tx_o <= 1'b1;
                end
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .uart_rx_i     (uart_rx_i),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .rx_frame_err_o(rx_frame_err_o),
        .rx_overrun_o  (rx_overrun_o)
    );

endmodule
